// File: rtl/nvdla_csb_target.sv
// CSB responder: local register bank, sticky maskable interrupt status,
// one outstanding request at a time through an IDLE/EXEC/RESP sequence.
module nvdla_csb_target #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          N_REGS    = 8,
  parameter int          N_INTR    = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   csb2nvdla_valid_i,
  output logic                   csb2nvdla_ready_o,
  input  logic [15:0]            csb2nvdla_addr_i,
  input  logic [31:0]            csb2nvdla_wdat_i,
  input  logic                   csb2nvdla_write_i,
  input  logic                   csb2nvdla_nposted_i,
  output logic                   nvdla2csb_valid_o,
  output logic [31:0]            nvdla2csb_data_o,
  output logic                   nvdla2csb_wr_complete_o,
  input  logic [N_INTR-1:0]      intr_set_i,
  output logic                   intr_o,
  output logic [N_REGS*32-1:0]   reg_o
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_q, state_d;
  logic [15:0]       addr_q;
  logic [31:0]       wdat_q;
  logic              write_q;
  logic              nposted_q;
  logic [31:0]       regs_q [N_REGS];
  logic [N_INTR-1:0] status_q;
  logic [N_INTR-1:0] mask_q;
  logic [N_INTR-1:0] w1c;
  logic [15:0]       err_q;
  logic [31:0]       rdata_q;
  logic [31:0]       rd;
  logic [15:0]       offset;
  logic              in_range;
  logic              exec;
  logic              we;
  logic              hit_stat;
  logic              hit_mask;
  logic              hit_err;

  // Address decode of the latched request
  always_comb begin
    offset   = addr_q - BASE_ADDR;
    in_range = (addr_q >= BASE_ADDR) && (offset < 16'(N_REGS + 3));
    exec     = (state_q == EXEC);
    we       = exec && write_q && in_range;
    hit_stat = (offset == 16'(N_REGS));
    hit_mask = (offset == 16'(N_REGS + 1));
    hit_err  = (offset == 16'(N_REGS + 2));
    w1c      = (we && hit_stat) ? wdat_q[N_INTR-1:0] : '0;
  end

  // Read data mux; out-of-range reads return zero
  always_comb begin
    rd = '0;
    if (in_range) begin
      for (int i = 0; i < N_REGS; i++)
        if (offset == 16'(i)) rd = regs_q[i];
      if (hit_stat) rd = 32'(status_q);
      if (hit_mask) rd = 32'(mask_q);
      if (hit_err)  rd = 32'(err_q);
    end
  end

  // Next-state logic; clear forces IDLE from any state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (csb2nvdla_valid_i) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Request capture on the IDLE handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q    <= '0;
      wdat_q    <= '0;
      write_q   <= 1'b0;
      nposted_q <= 1'b0;
    end else if (clear_i) begin
      addr_q    <= '0;
      wdat_q    <= '0;
      write_q   <= 1'b0;
      nposted_q <= 1'b0;
    end else if (state_q == IDLE && csb2nvdla_valid_i) begin
      addr_q    <= csb2nvdla_addr_i;
      wdat_q    <= csb2nvdla_wdat_i;
      write_q   <= csb2nvdla_write_i;
      nposted_q <= csb2nvdla_nposted_i;
    end
  end

  // Register bank, read capture and error address updated in EXEC
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_REGS; i++) regs_q[i] <= '0;
      mask_q  <= '0;
      err_q   <= '0;
      rdata_q <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < N_REGS; i++) regs_q[i] <= '0;
      mask_q  <= '0;
      err_q   <= '0;
      rdata_q <= '0;
    end else begin
      for (int i = 0; i < N_REGS; i++)
        if (we && offset == 16'(i)) regs_q[i] <= wdat_q;
      if (we && hit_mask) mask_q <= wdat_q[N_INTR-1:0];
      if (exec && !in_range) err_q <= addr_q;
      if (exec && !write_q) rdata_q <= rd;
    end
  end

  // Sticky status: a same-cycle set overrides write-1-to-clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      status_q <= '0;
    else if (clear_i) status_q <= '0;
    else              status_q <= (status_q & ~w1c) | intr_set_i;
  end

  // Outputs
  always_comb begin
    csb2nvdla_ready_o       = (state_q == IDLE);
    nvdla2csb_valid_o       = (state_q == RESP) && !write_q;
    nvdla2csb_wr_complete_o = (state_q == RESP) && write_q && nposted_q;
    nvdla2csb_data_o        = rdata_q;
    intr_o                  = |(status_q & mask_q);
    for (int i = 0; i < N_REGS; i++) reg_o[i*32 +: 32] = regs_q[i];
  end

endmodule

// File: doc/nvdla_csb_target.md
# nvdla_csb_target

CSB responder terminating the NVDLA configuration space bus. It accepts single-beat CSB requests (address, write data, write flag, non-posted flag) from a CSB initiator such as the HWPE control FSM. It executes them against a local bank of 32-bit registers and returns read data or non-posted write completions. It also owns a maskable, sticky interrupt status register whose OR-reduced output is the interrupt that a wait-for-interrupt initiator polls.

## Interface
- BASE_ADDR, 16'h0000: CSB word address of register offset 0.
- N_REGS, 8: number of general-purpose R/W registers (1..64).
- N_INTR, 4: number of interrupt sources (1..32).
- clk_i  in  1  clock; all logic on rising edge.
- rst_ni  in  1  reset. One clock; reset is asynchronous and active-low.
- clear_i  in  1  synchronous clear; same effect as reset, taken on the next edge.
- csb2nvdla_valid_i  in  1  request valid.
- csb2nvdla_ready_o  out  1  request ready.
- csb2nvdla_addr_i  in  16  CSB word address.
- csb2nvdla_wdat_i  in  32  write data.
- csb2nvdla_write_i  in  1  1 = write, 0 = read.
- csb2nvdla_nposted_i  in  1  write requires completion pulse.
- nvdla2csb_valid_o  out  1  read response valid, 1-cycle pulse.
- nvdla2csb_data_o  out  32  read data, valid with nvdla2csb_valid_o.
- nvdla2csb_wr_complete_o  out  1  non-posted write completion, 1-cycle pulse.
- intr_set_i  in  N_INTR  level/pulse interrupt set per source.
- intr_o  out  1  |(INTR_STATUS & INTR_MASK).
- reg_o  out  N_REGS×32  current general register contents.

## Operation
- Offset = addr − BASE_ADDR, computed modulo 2^16. The request is in range iff addr ≥ BASE_ADDR and offset < N_REGS+3.
- Map:
  - 0..N_REGS-1: general regs, R/W, reset 0.
  - N_REGS: INTR_STATUS, N_INTR bits. Write-1-to-clear; reads zero-extended.
  - N_REGS+1: INTR_MASK, R/W, N_INTR bits, reset 0. Upper write bits ignored.
  - N_REGS+2: ERR_ADDR, RO. Holds the last out-of-range address; reset 0.
- Out-of-range write: no register changes, ERR_ADDR updated, completion still issued if non-posted.
- Out-of-range read: returns 0, ERR_ADDR updated.
- Writes to RO offsets are ignored; they are not errors.
- FSM has three states:
  - IDLE: ready=1. Moves to EXEC on valid&ready, latching addr/wdat/write/nposted.
  - EXEC: ready=0. Performs the write or captures the read data; moves to RESP.
  - RESP: ready=0. Pulses nvdla2csb_valid_o for a read, or nvdla2csb_wr_complete_o for a non-posted write; nothing for a posted write. Moves to IDLE.
- Only one request is outstanding at a time; there is no response back-pressure.
- INTR_STATUS[i] is set on any edge where intr_set_i[i]=1.
- If a set and a W1C hit the same bit in the same cycle, the set wins.
- Bits not being set and written with 1 are cleared.
- Reset and clear_i drive: FSM to IDLE, all registers to 0, any pending response discarded (no pulse).

## Timing
- Reset values: csb2nvdla_ready_o=1, nvdla2csb_valid_o=0, nvdla2csb_data_o=0, nvdla2csb_wr_complete_o=0, intr_o=0, reg_o=0.
- Request handshake at cycle 0 (edge at end of cycle 0).
- EXEC in cycle 1. Write effect is visible on reg_o and intr_o from cycle 2.
- Response pulse in cycle 2. Read data is held at the captured value until the next read response; it is 0 after reset.
- ready returns to 1 in cycle 3. Peak throughput is 1 request per 3 cycles.
- A read in cycle 1 returns register state before any same-edge intr_set_i update.
- intr_set_i asserted in cycle t with mask set gives intr_o=1 in cycle t+1.
- intr_o is combinational from registers only, with no input-to-output path.
- Valid held high while ready=0 is not accepted. It is accepted in the first IDLE cycle.
- clear_i asserted during EXEC/RESP: the next cycle is IDLE with no pulse; the write is lost if clear_i is asserted in EXEC.

## Test plan
- Reset, then non-posted write addr=BASE_ADDR+2, wdat=32'hDEADBEEF -> wr_complete pulses in cycle 2; reg_o[2]=32'hDEADBEEF from cycle 2; read of the same address returns 32'hDEADBEEF with valid pulse.
- Posted write -> no wr_complete; back-to-back valid held high -> second request accepted exactly 3 cycles after the first.
- Set INTR_MASK=4'b0101, pulse intr_set_i=4'b0011 -> INTR_STATUS=4'b0011 and intr_o=1 next cycle. Write 4'b0001 to INTR_STATUS -> status 4'b0010, intr_o=0.
- intr_set_i[1]=1 during the EXEC of a W1C write of 4'b0010 -> INTR_STATUS[1] stays 1.
- Read at addr=BASE_ADDR+N_REGS+3 and at BASE_ADDR−1 (when BASE_ADDR>0) -> data 0, valid pulse; ERR_ADDR reads the offending address; no register changed.
- clear_i asserted in EXEC of a non-posted write -> no wr_complete, target reg stays 0, ready=1 next cycle.
